laser_frame_receiver: RTL and testbench

LASER_FRAME_RECEIVER -- requirements
Module: laser_frame_receiver

---
 rtl/laser_frame_receiver.sv | 212 +++++++++++++++++++++
 tb/tb_laser_frame_receiver.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/laser_frame_receiver.sv
// Two-lane oversampled laser frame receiver: synchronizes both photodiode lanes, majority-votes
// each bit mid-period, and hands the decoded byte pair out on a held valid/ready interface.
module laser_frame_receiver #(
  parameter int OVERSAMPLE = 8,  // even, 6..64
  parameter int ERRW       = 8
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            laser1_in,
  input  logic            laser2_in,
  input  logic            out_ready,
  input  logic            err_clear,
  output logic            out_valid,
  output logic [7:0]      data1_out,
  output logic [7:0]      data2_out,
  output logic            overrun,
  output logic [ERRW-1:0] frame_err_cnt,
  output logic            busy,
  output logic [1:0]      state_dbg
);

  // Output handshake: a byte pair is transferred on every clock edge where out_valid and
  // out_ready are both high; out_valid and the data stay frozen until that edge.

  localparam int PW = $clog2(OVERSAMPLE);
  localparam logic [PW-1:0] PH_LAST = PW'(OVERSAMPLE - 1);
  localparam logic [PW-1:0] PH_A    = PW'(OVERSAMPLE / 2 - 1);
  localparam logic [PW-1:0] PH_B    = PW'(OVERSAMPLE / 2);
  localparam logic [PW-1:0] PH_V    = PW'(OVERSAMPLE / 2 + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MARKER = 2'd1,
    DATA   = 2'd2,
    STOP   = 2'd3
  } state_t;

  logic s1_meta_q, s1_q, s2_meta_q, s2_q;
  logic s1_prev_q, s2_prev_q;
  logic [1:0] settle_q;

  state_t state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [3:0] bit_q, bit_d;
  logic a1_q, a1_d, b1_q, b1_d, a2_q, a2_d, b2_q, b2_d;
  logic [7:0] sh1_q, sh1_d, sh2_q, sh2_d;
  logic valid_q, valid_d;
  logic [7:0] d1_q, d1_d, d2_q, d2_d;
  logic ovr_q, ovr_d;
  logic [ERRW-1:0] err_q, err_d;

  logic settled, rise_any, vote1, vote2, wrap, vote_cyc, hs, err_inc, good;

  // Edge detection is held off until the synchronizer and the previous-value register both
  // carry real line samples, so a line already high at reset release is not taken as a rise.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_meta_q <= 1'b0;
      s1_q      <= 1'b0;
      s2_meta_q <= 1'b0;
      s2_q      <= 1'b0;
      s1_prev_q <= 1'b0;
      s2_prev_q <= 1'b0;
      settle_q  <= 2'd0;
    end else begin
      s1_meta_q <= laser1_in;
      s1_q      <= s1_meta_q;
      s2_meta_q <= laser2_in;
      s2_q      <= s2_meta_q;
      s1_prev_q <= s1_q;
      s2_prev_q <= s2_q;
      if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
    end
  end

  assign settled  = (settle_q == 2'd3);
  assign rise_any = settled & ((s1_q & ~s1_prev_q) | (s2_q & ~s2_prev_q));
  assign vote1    = (a1_q & b1_q) | (a1_q & s1_q) | (b1_q & s1_q);
  assign vote2    = (a2_q & b2_q) | (a2_q & s2_q) | (b2_q & s2_q);
  assign wrap     = (phase_q == PH_LAST);
  assign vote_cyc = (phase_q == PH_V);
  assign hs       = valid_q & out_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      phase_q <= '0;
      bit_q   <= 4'd0;
      a1_q    <= 1'b0;
      b1_q    <= 1'b0;
      a2_q    <= 1'b0;
      b2_q    <= 1'b0;
      sh1_q   <= 8'd0;
      sh2_q   <= 8'd0;
      valid_q <= 1'b0;
      d1_q    <= 8'd0;
      d2_q    <= 8'd0;
      ovr_q   <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      a1_q    <= a1_d;
      b1_q    <= b1_d;
      a2_q    <= a2_d;
      b2_q    <= b2_d;
      sh1_q   <= sh1_d;
      sh2_q   <= sh2_d;
      valid_q <= valid_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      ovr_q   <= ovr_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    a1_d    = a1_q;
    b1_d    = b1_q;
    a2_d    = a2_q;
    b2_d    = b2_q;
    sh1_d   = sh1_q;
    sh2_d   = sh2_q;
    err_inc = 1'b0;
    good    = 1'b0;

    if (state_q == IDLE) begin
      phase_d = '0;
      bit_d   = 4'd1;
      if (rise_any) state_d = MARKER;
    end else begin
      phase_d = wrap ? '0 : phase_q + PW'(1);
      if (phase_q == PH_A) begin
        a1_d = s1_q;
        a2_d = s2_q;
      end
      if (phase_q == PH_B) begin
        b1_d = s1_q;
        b2_d = s2_q;
      end
    end

    case (state_q)
      MARKER: begin
        if (vote_cyc && !(vote1 && vote2)) begin
          err_inc = 1'b1;
          state_d = IDLE;
        end else if (wrap) begin
          state_d = DATA;
          bit_d   = bit_q + 4'd1;
        end
      end
      DATA: begin
        if (vote_cyc) begin
          sh1_d = {vote1, sh1_q[7:1]};
          sh2_d = {vote2, sh2_q[7:1]};
        end
        if (wrap) begin
          bit_d = bit_q + 4'd1;
          if (bit_q == 4'd9) state_d = STOP;
        end
      end
      STOP: begin
        if (vote_cyc) begin
          state_d = IDLE;
          if (vote1 || vote2) err_inc = 1'b1;
          else good = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // A good frame may replace the held pair only when the slot is empty or is being
  // accepted in the same cycle; otherwise it is dropped and flagged.
  always_comb begin
    valid_d = valid_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    ovr_d   = ovr_q;
    err_d   = err_q;

    if (good && (!valid_q || hs)) begin
      valid_d = 1'b1;
      d1_d    = sh1_q;
      d2_d    = sh2_q;
    end else begin
      if (good) ovr_d = 1'b1;
      if (hs) valid_d = 1'b0;
    end

    if (err_inc && (err_q != {ERRW{1'b1}})) err_d = err_q + ERRW'(1);

    if (err_clear) begin
      err_d = '0;
      ovr_d = 1'b0;
    end
  end

  assign out_valid     = valid_q;
  assign data1_out     = d1_q;
  assign data2_out     = d2_q;
  assign overrun       = ovr_q;
  assign frame_err_cnt = err_q;
  assign busy          = (state_q != IDLE);
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_laser_frame_receiver.sv
// Bench for laser_frame_receiver: drives whole laser frames bit period by bit period and
// compares received byte pairs and error counts against a frame-level model.
module tb_laser_frame_receiver;

  localparam int OS = 8;

  logic clock = 1'b0;
  logic reset_n;
  logic laser1_in, laser2_in, out_ready, err_clear;
  logic out_valid, overrun, busy;
  logic [7:0] data1_out, data2_out;
  logic [7:0] frame_err_cnt;
  logic [1:0] state_dbg;

  laser_frame_receiver #(.OVERSAMPLE(OS), .ERRW(8)) dut (
    .clock(clock), .reset_n(reset_n), .laser1_in(laser1_in), .laser2_in(laser2_in),
    .out_ready(out_ready), .err_clear(err_clear), .out_valid(out_valid),
    .data1_out(data1_out), .data2_out(data2_out), .overrun(overrun),
    .frame_err_cnt(frame_err_cnt), .busy(busy), .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int exp_err = 0;
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  logic l1_v = 1'b0, l2_v = 1'b0, rdy_v = 1'b1, clr_v = 1'b0;

  // One clock: apply the pending input values at the falling edge and record any pair that
  // the next rising edge will transfer.
  task automatic tick();
    @(negedge clock);
    laser1_in = l1_v;
    laser2_in = l2_v;
    out_ready = rdy_v;
    err_clear = clr_v;
    if (reset_n && out_valid && out_ready) got_q.push_back({data1_out, data2_out});
  endtask

  task automatic idle(input int n);
    l1_v = 1'b0;
    l2_v = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input logic stp, input int j);
    if (j == 0) return 1'b0;
    if (j == 1) return 1'b1;
    if (j == 10) return stp;
    return b[j-2];
  endfunction

  task automatic drive_bits(input logic [7:0] b1, input logic [7:0] b2, input logic st1,
                            input logic st2, input logic glitch, input int nticks);
    for (int t = 0; t < nticks; t++) begin
      int j;
      int c;
      logic flip;
      j = t / OS;
      c = t % OS;
      flip = glitch && (j >= 2) && (j <= 9) && (c == 4);
      l1_v = frame_bit(b1, st1, j) ^ flip;
      l2_v = frame_bit(b2, st2, j) ^ flip;
      tick();
    end
  endtask

  task automatic send_frame(input logic [7:0] b1, input logic [7:0] b2, input logic st1,
                            input logic st2, input logic glitch);
    drive_bits(b1, b2, st1, st2, glitch, 11 * OS);
    idle(2 * OS);
    if (st1 || st2) begin
      if (exp_err < 255) exp_err++;
    end
  endtask

  task automatic send_pulse(input int lane);
    l1_v = (lane == 1);
    l2_v = (lane == 2);
    for (int i = 0; i < OS; i++) tick();
    idle(OS);
    if (exp_err < 255) exp_err++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle(3);
    checks++;
    if (out_valid !== 1'b0 || overrun !== 1'b0 || busy !== 1'b0 || state_dbg !== 2'd0) begin
      failures++;
      $display("FAIL reset_flags: valid=%b ovr=%b busy=%b st=%0d required 0/0/0/0",
               out_valid, overrun, busy, state_dbg);
    end
    checks++;
    if (data1_out !== 8'd0 || data2_out !== 8'd0 || frame_err_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_data: d1=%h d2=%h cnt=%0d required 00/00/0",
               data1_out, data2_out, frame_err_cnt);
    end
    reset_n = 1'b1;
    exp_err = 0;
    idle(6);
  endtask

  task automatic test_basic();
    rdy_v = 1'b1;
    send_frame(8'hA5, 8'h3C, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(16'hA53C);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL basic_count: got %0d pairs required %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [15:0] g, e;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL basic_data: got %h required %h", g, e);
      end
    end
    got_q.delete();
    exp_q.delete();
    checks++;
    if (frame_err_cnt !== 8'(exp_err)) begin
      failures++;
      $display("FAIL basic_errcnt: got %0d required %0d", frame_err_cnt, exp_err);
    end
  endtask

  task automatic test_glitch();
    send_frame(8'hA5, 8'h3C, 1'b0, 1'b0, 1'b1);
    exp_q.push_back(16'hA53C);
    checks++;
    if (got_q.size() != 1) begin
      failures++;
      $display("FAIL glitch_count: got %0d pairs required 1", got_q.size());
    end
    if (got_q.size() > 0) begin
      logic [15:0] g, e;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL glitch_data: got %h required %h", g, e);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_stop_err();
    send_frame(8'h5A, 8'hC3, 1'b0, 1'b1, 1'b0);
    checks++;
    if (got_q.size() != 0) begin
      failures++;
      $display("FAIL stop_err_output: got %0d pairs required 0", got_q.size());
    end
    checks++;
    if (frame_err_cnt !== 8'(exp_err)) begin
      failures++;
      $display("FAIL stop_err_cnt: got %0d required %0d", frame_err_cnt, exp_err);
    end
    got_q.delete();
  endtask

  task automatic test_marker_err();
    send_pulse(1);
    checks++;
    if (frame_err_cnt !== 8'(exp_err) || busy !== 1'b0 || state_dbg !== 2'd0) begin
      failures++;
      $display("FAIL marker_err: cnt=%0d busy=%b st=%0d required %0d/0/0",
               frame_err_cnt, busy, state_dbg, exp_err);
    end
    checks++;
    if (got_q.size() != 0) begin
      failures++;
      $display("FAIL marker_err_output: got %0d pairs required 0", got_q.size());
    end
    got_q.delete();
  endtask

  task automatic test_overrun();
    rdy_v = 1'b0;
    send_frame(8'h11, 8'h22, 1'b0, 1'b0, 1'b0);
    send_frame(8'h33, 8'h44, 1'b0, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || data1_out !== 8'h11 || data2_out !== 8'h22) begin
      failures++;
      $display("FAIL overrun_held: valid=%b d1=%h d2=%h required 1/11/22",
               out_valid, data1_out, data2_out);
    end
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_flag: got %b required 1", overrun);
    end
    rdy_v = 1'b1;
    idle(4);
    checks++;
    if (got_q.size() != 1) begin
      failures++;
      $display("FAIL overrun_handshakes: got %0d required 1", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== 16'h1122) begin
        failures++;
        $display("FAIL overrun_data: got %h required 1122", got_q[0]);
      end
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL overrun_drop_valid: got %b required 0", out_valid);
    end
    got_q.delete();
  endtask

  task automatic test_err_clear();
    clr_v = 1'b1;
    send_pulse(2);
    clr_v = 1'b0;
    exp_err = 0;
    idle(2);
    checks++;
    if (frame_err_cnt !== 8'd0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL err_clear: cnt=%0d ovr=%b required 0/0", frame_err_cnt, overrun);
    end
  endtask

  task automatic test_reset_mid();
    drive_bits(8'h5A, 8'hA5, 1'b0, 1'b0, 1'b0, 5 * OS + 3);
    reset_n = 1'b0;
    l1_v = 1'b0;
    l2_v = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || frame_err_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_mid_async: busy=%b valid=%b cnt=%0d required 0/0/0",
               busy, out_valid, frame_err_cnt);
    end
    idle(4);
    reset_n = 1'b1;
    exp_err = 0;
    idle(20);
    send_frame(8'h0F, 8'hF0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (got_q.size() != 1) begin
      failures++;
      $display("FAIL reset_mid_count: got %0d pairs required 1", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== 16'h0FF0) begin
        failures++;
        $display("FAIL reset_mid_data: got %h required 0ff0", got_q[0]);
      end
    end
    checks++;
    if (frame_err_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_mid_cnt: got %0d required 0", frame_err_cnt);
    end
    got_q.delete();
  endtask

  task automatic test_high_at_reset();
    reset_n = 1'b0;
    l1_v = 1'b1;
    l2_v = 1'b1;
    tick();
    tick();
    reset_n = 1'b1;
    exp_err = 0;
    for (int i = 0; i < 30; i++) tick();
    checks++;
    if (busy !== 1'b0 || frame_err_cnt !== 8'd0) begin
      failures++;
      $display("FAIL high_at_reset: busy=%b cnt=%0d required 0/0", busy, frame_err_cnt);
    end
    idle(10);
    send_frame(8'h77, 8'h88, 1'b0, 1'b0, 1'b0);
    checks++;
    if (got_q.size() != 1 || (got_q.size() == 1 && got_q[0] !== 16'h7788)) begin
      failures++;
      $display("FAIL high_at_reset_frame: got %0d pairs first=%h required 1 pair 7788",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 16'h0);
    end
    got_q.delete();
  endtask

  task automatic test_random();
    rdy_v = 1'b1;
    for (int n = 0; n < 24; n++) begin
      int kind;
      logic [7:0] b1, b2;
      kind = $urandom_range(0, 3);
      b1 = 8'($urandom_range(0, 255));
      b2 = 8'($urandom_range(0, 255));
      if (kind <= 1) begin
        send_frame(b1, b2, 1'b0, 1'b0, 1'(kind));
        exp_q.push_back({b1, b2});
      end else if (kind == 2) begin
        int m;
        m = $urandom_range(1, 3);
        send_frame(b1, b2, m[0], m[1], 1'b0);
      end else begin
        send_pulse($urandom_range(1, 2));
      end
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL random_count: got %0d pairs required %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [15:0] g, e;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL random_data: got %h required %h", g, e);
      end
    end
    got_q.delete();
    exp_q.delete();
    checks++;
    if (frame_err_cnt !== 8'(exp_err)) begin
      failures++;
      $display("FAIL random_errcnt: got %0d required %0d", frame_err_cnt, exp_err);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 260; i++) send_pulse($urandom_range(1, 2));
    checks++;
    if (frame_err_cnt !== 8'd255 || exp_err != 255) begin
      failures++;
      $display("FAIL saturation: got %0d required 255", frame_err_cnt);
    end
    clr_v = 1'b1;
    tick();
    clr_v = 1'b0;
    tick();
    exp_err = 0;
    checks++;
    if (frame_err_cnt !== 8'd0) begin
      failures++;
      $display("FAIL saturation_clear: got %0d required 0", frame_err_cnt);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    laser1_in = 1'b0;
    laser2_in = 1'b0;
    out_ready = 1'b1;
    err_clear = 1'b0;
    test_reset();
    test_basic();
    test_glitch();
    test_stop_err();
    test_marker_err();
    test_overrun();
    test_err_clear();
    test_reset_mid();
    test_high_at_reset();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
